// File: rtl/ktc32_pkg.sv
// Shared constants, state encoding and helpers for the KTC32 multicycle CPU.
package ktc32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_MUL
    } aluop_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/ktc32_alu.sv
// Combinational ALU for KTC32. MUL is present only when KTC32_MUL_EN is defined.
module ktc32_alu
    import ktc32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] y
);

    logic signed [31:0] sa;
    logic signed [31:0] sb;

    assign sa = a;
    assign sb = b;

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {31'd0, (sa < sb)};
`ifdef KTC32_MUL_EN
            ALU_MUL: y = a * b;
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/ktc32.sv
// KTC32 multicycle CPU: FSM, register file and datapath around one shared memory port.
// Optional R-type MUL (funct 0x18) is enabled by defining KTC32_MUL_EN.
module ktc32
    import ktc32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd,
    output logic        memwrite,
    output logic [31:0] addr,
    output logic [31:0] wd
);

    state_t      state;
    state_t      nstate;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] wd_q;
    logic [31:0] aluout;
    logic [31:0] mdr;
    aluop_t      aluop_q;
    aluop_t      dec_aluop;
    logic        rtype_ok;
    logic [31:0] alu_y;
    logic [31:0] regs [NREGS];

    logic [5:0]  op;
    logic [4:0]  rdi;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [5:0]  funct;
    logic [31:0] imm;

    assign op    = ir[31:26];
    assign rdi   = ir[25:21];
    assign rs1   = ir[20:16];
    assign rs2   = ir[15:11];
    assign funct = ir[5:0];
    assign imm   = sext16(ir[15:0]);
    assign wd    = wd_q;

    ktc32_alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (aluop_q),
        .y  (alu_y)
    );

    // Undefined funct codes fall back to NOP by sending DECODE straight to FETCH.
    always_comb begin
        dec_aluop = ALU_ADD;
        rtype_ok  = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                F_ADD: begin rtype_ok = 1'b1; dec_aluop = ALU_ADD; end
                F_SUB: begin rtype_ok = 1'b1; dec_aluop = ALU_SUB; end
                F_AND: begin rtype_ok = 1'b1; dec_aluop = ALU_AND; end
                F_OR:  begin rtype_ok = 1'b1; dec_aluop = ALU_OR;  end
                F_XOR: begin rtype_ok = 1'b1; dec_aluop = ALU_XOR; end
                F_SLT: begin rtype_ok = 1'b1; dec_aluop = ALU_SLT; end
                F_MUL: begin
`ifdef KTC32_MUL_EN
                    rtype_ok  = 1'b1;
                    dec_aluop = ALU_MUL;
`else
                    rtype_ok  = 1'b0;
`endif
                end
                default: rtype_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= nstate;
    end

    always_comb begin
        nstate   = state;
        memwrite = 1'b0;
        addr     = pc;
        case (state)
            S_FETCH:  nstate = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:       nstate = rtype_ok ? S_EXEC : S_FETCH;
                    OP_ADDI:        nstate = S_EXEC;
                    OP_LW, OP_SW:   nstate = S_MEMADR;
                    OP_BEQ, OP_BNE: nstate = S_BRANCH;
                    OP_J:           nstate = S_JUMP;
                    default:        nstate = S_FETCH;
                endcase
            end
            S_EXEC:   nstate = S_ALUWB;
            S_ALUWB:  nstate = S_FETCH;
            S_MEMADR: nstate = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                addr   = aluout;
                nstate = S_MEMWB;
            end
            S_MEMWB:  nstate = S_FETCH;
            S_MEMWR: begin
                addr     = aluout;
                memwrite = 1'b1;
                nstate   = S_FETCH;
            end
            S_BRANCH: nstate = S_FETCH;
            S_JUMP:   nstate = S_FETCH;
            default:  nstate = S_FETCH;
        endcase
    end

    // PC already holds PC_of_instr+4 once FETCH completes, so branch and jump build on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            aluout  <= '0;
            mdr     <= '0;
            aluop_q <= ALU_ADD;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= rd;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a_q     <= regs[rs1];
                    b_q     <= (op == OP_RTYPE) ? regs[rs2] : imm;
                    wd_q    <= regs[rdi];
                    aluop_q <= dec_aluop;
                end
                S_EXEC, S_MEMADR: aluout <= alu_y;
                S_ALUWB: if (rdi != 5'd0) regs[rdi] <= aluout;
                S_MEMRD: mdr <= rd;
                S_MEMWB: if (rdi != 5'd0) regs[rdi] <= mdr;
                S_BRANCH: begin
                    if ((wd_q == a_q) == (op == OP_BEQ))
                        pc <= pc + {b_q[29:0], 2'b00};
                end
                S_JUMP: pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ktc32.sv
// Self-checking bench for ktc32: directed programs, a vector table and random programs vs an ISA model.
module tb_ktc32;

    localparam logic [5:0] T_J = 6'h02, T_BEQ = 6'h04, T_BNE = 6'h05, T_ADDI = 6'h08;
    localparam logic [5:0] T_LW = 6'h23, T_SW = 6'h2B;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } ev_t;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          c;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rdata;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wd;

    logic [31:0] mem [256];
    logic [31:0] img [256];
    logic [31:0] alog [64];
    int          cyc;
    ev_t         ev_q [$];
    ev_t         exp_q [$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] ff_addr;

    ktc32 dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rdata),
        .memwrite (memwrite),
        .addr     (addr),
        .wd       (wd)
    );

    always #5 clk = ~clk;

    assign rdata = mem[addr[9:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (memwrite) begin
            mem[addr[9:2]] <= wd;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 1;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (cyc < 64) alog[cyc] = addr;
            if (memwrite) ev_q.push_back('{addr, wd, cyc});
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] d,
                                          input logic [4:0] s, input logic [4:0] t);
        return {6'h00, d, s, t, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] d,
                                          input logic [4:0] s, input logic [15:0] im);
        return {o, d, s, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] w);
        return {T_J, w};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = '0;
    endtask

    task automatic run_prog(input int ncyc, output int base);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        base = ev_q.size();
        #1 reset = 1'b0;
        #1 ff_addr = addr;
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_events(input string nm, input int base);
        int n;
        n = ev_q.size() - base;
        chk($sformatf("%s.nstores", nm), 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            chk($sformatf("%s.store%0d", nm, i), {ev_q[base+i].a, ev_q[base+i].d},
                {exp_q[i].a, exp_q[i].d});
            chk($sformatf("%s.cycle%0d", nm, i), 64'(ev_q[base+i].c), 64'(exp_q[i].c));
        end
    endtask

    // Instruction-level reference: executes the program image and lists every store
    // with the cycle it commits in, from the per-class instruction latencies.
    task automatic model_run(output int tend);
        logic [31:0] r [32];
        logic [31:0] mm [256];
        logic [31:0] pc, ins, x, y, v, imm, res, ea, npc;
        logic [4:0]  rdn;
        bit          wr;
        int          t, lat;
        mm = img;
        for (int i = 0; i < 32; i++) r[i] = '0;
        pc = '0;
        t = 0;
        exp_q.delete();
        for (int step = 0; step < 4000; step++) begin
            ins = mm[pc[9:2]];
            rdn = ins[25:21];
            x   = r[ins[20:16]];
            y   = r[ins[15:11]];
            v   = r[rdn];
            imm = {{16{ins[15]}}, ins[15:0]};
            npc = pc + 32'd4;
            wr  = 0;
            res = '0;
            lat = 2;
            case (ins[31:26])
                6'h00: begin
                    lat = 4;
                    wr  = 1;
                    case (ins[5:0])
                        6'h20: res = x + y;
                        6'h22: res = x - y;
                        6'h24: res = x & y;
                        6'h25: res = x | y;
                        6'h26: res = x ^ y;
                        6'h2A: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`ifdef KTC32_MUL_EN
                        6'h18: res = x * y;
`endif
                        default: begin wr = 0; lat = 2; end
                    endcase
                end
                T_ADDI: begin lat = 4; wr = 1; res = x + imm; end
                T_LW: begin
                    lat = 5;
                    wr  = 1;
                    ea  = x + imm;
                    res = mm[ea[9:2]];
                end
                T_SW: begin
                    lat = 4;
                    ea  = x + imm;
                    exp_q.push_back('{ea, v, t + 4});
                    mm[ea[9:2]] = v;
                end
                T_BEQ, T_BNE: begin
                    lat = 3;
                    if ((v == x) != (ins[31:26] == T_BNE)) npc = pc + 32'd4 + (imm << 2);
                end
                T_J: begin
                    lat = 3;
                    npc = {npc[31:28], ins[25:0], 2'b00};
                    if (npc == pc) break;
                end
                default: lat = 2;
            endcase
            if (wr && rdn != 5'd0) r[rdn] = res;
            t  += lat;
            pc = npc;
        end
        tend = t;
    endtask

    task automatic gen_random();
        logic [5:0]  fl [8];
        logic [4:0]  d, s, t2;
        logic [15:0] k;
        int          n;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h18, 6'h27};
        clear_img();
        for (int i = 128; i < 256; i++) img[i] = $urandom;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            d  = 5'($urandom_range(0, 7));
            s  = 5'($urandom_range(0, 7));
            t2 = 5'($urandom_range(0, 7));
            k  = 16'(16'h0200 + 4 * $urandom_range(0, 127));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 9: img[n] = enc_r(fl[$urandom_range(0, 7)], d, s, t2);
                4: img[n] = enc_i(T_ADDI, d, s, 16'($urandom));
                5: img[n] = enc_i(T_LW, d, 5'd0, k);
                6: img[n] = enc_i(T_SW, d, 5'd0, k);
                7: img[n] = enc_i($urandom_range(0, 1) ? T_BEQ : T_BNE, d, s, 16'd1);
                default: img[n] = {6'h3F, 26'($urandom)};
            endcase
            n++;
        end
        for (int i = 1; i < 8; i++) begin
            img[n] = enc_i(T_SW, 5'(i), 5'd0, 16'(16'h0300 + 4 * i));
            n++;
        end
        img[n] = enc_j(26'(n));
    endtask

    vec_t tbl [12];

    initial begin
        int base, tend;
        logic [31:0] mul_y;
        int          mul_c;

`ifdef KTC32_MUL_EN
        mul_y = 32'hFFFF_FFFA;
        mul_c = 18;
`else
        mul_y = 32'h0;
        mul_c = 16;
`endif
        tbl[0]  = '{6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 18};
        tbl[1]  = '{6'h20, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 18};
        tbl[2]  = '{6'h22, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 18};
        tbl[3]  = '{6'h22, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 18};
        tbl[4]  = '{6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 18};
        tbl[5]  = '{6'h25, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 18};
        tbl[6]  = '{6'h26, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 18};
        tbl[7]  = '{6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 18};
        tbl[8]  = '{6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 18};
        tbl[9]  = '{6'h2A, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 18};
        tbl[10] = '{6'h18, 32'h0000_0003, 32'hFFFF_FFFE, mul_y, mul_c};
        tbl[11] = '{6'h27, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_0000, 16};

        // Reset held: outputs parked at the reset PC, no store strobe.
        clear_img();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset.addr", 64'(addr), 64'h0);
            chk("reset.memwrite", 64'(memwrite), 64'h0);
        end

        // Register arithmetic then a single store.
        clear_img();
        img[0] = enc_i(T_ADDI, 5'd1, 5'd0, 16'd3);
        img[1] = enc_i(T_ADDI, 5'd2, 5'd0, 16'd4);
        img[2] = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
        img[3] = enc_i(T_SW, 5'd3, 5'd0, 16'd84);
        img[4] = enc_j(26'd4);
        exp_q.delete();
        exp_q.push_back('{32'd84, 32'd7, 16});
        run_prog(24, base);
        chk("seq_add.first_fetch", 64'(ff_addr), 64'h0);
        chk("seq_add.memwr_addr", 64'(alog[16]), 64'd84);
        check_events("seq_add", base);

        // Store, load back, store again.
        clear_img();
        img[0] = enc_i(T_ADDI, 5'd1, 5'd0, 16'h0055);
        img[1] = enc_i(T_SW, 5'd1, 5'd0, 16'd80);
        img[2] = enc_i(T_LW, 5'd4, 5'd0, 16'd80);
        img[3] = enc_i(T_SW, 5'd4, 5'd0, 16'd88);
        img[4] = enc_j(26'd4);
        exp_q.delete();
        exp_q.push_back('{32'd80, 32'h55, 8});
        exp_q.push_back('{32'd88, 32'h55, 17});
        run_prog(26, base);
        check_events("seq_lwsw", base);

        // Signed compare, negate, self-xor, and a write to r0 that must not stick.
        clear_img();
        img[0] = enc_i(T_ADDI, 5'd1, 5'd0, 16'hFFFF);
        img[1] = enc_r(6'h2A, 5'd5, 5'd1, 5'd0);
        img[2] = enc_r(6'h22, 5'd6, 5'd0, 5'd1);
        img[3] = enc_r(6'h26, 5'd7, 5'd1, 5'd1);
        img[4] = enc_i(T_ADDI, 5'd0, 5'd0, 16'd5);
        img[5] = enc_i(T_SW, 5'd5, 5'd0, 16'h0200);
        img[6] = enc_i(T_SW, 5'd6, 5'd0, 16'h0204);
        img[7] = enc_i(T_SW, 5'd7, 5'd0, 16'h0208);
        img[8] = enc_i(T_SW, 5'd0, 5'd0, 16'h020C);
        img[9] = enc_j(26'd9);
        exp_q.delete();
        exp_q.push_back('{32'h200, 32'd1, 24});
        exp_q.push_back('{32'h204, 32'd1, 28});
        exp_q.push_back('{32'h208, 32'd0, 32});
        exp_q.push_back('{32'h20C, 32'd0, 36});
        run_prog(42, base);
        check_events("seq_slt", base);

        // Taken BEQ skips a store, untaken BNE falls through, J lands on word 0x10.
        clear_img();
        img[0]  = enc_i(T_ADDI, 5'd1, 5'd0, 16'd9);
        img[1]  = enc_i(T_BEQ, 5'd0, 5'd0, 16'd1);
        img[2]  = enc_i(T_SW, 5'd1, 5'd0, 16'h0200);
        img[3]  = enc_i(T_BNE, 5'd0, 5'd0, 16'd1);
        img[4]  = enc_i(T_SW, 5'd1, 5'd0, 16'h0204);
        img[5]  = enc_j(26'h10);
        img[16] = enc_i(T_SW, 5'd1, 5'd0, 16'h0208);
        img[17] = enc_j(26'h11);
        exp_q.delete();
        exp_q.push_back('{32'h204, 32'd9, 14});
        exp_q.push_back('{32'h208, 32'd9, 21});
        run_prog(28, base);
        chk("seq_br.beq_target", 64'(alog[8]), 64'h0C);
        chk("seq_br.j_target", 64'(alog[18]), 64'h40);
        check_events("seq_br", base);

        // Reset during MEMADR of a store aborts it; execution restarts from PC 0.
        clear_img();
        img[0] = enc_i(T_ADDI, 5'd1, 5'd0, 16'd5);
        img[1] = enc_i(T_SW, 5'd1, 5'd0, 16'h0200);
        img[2] = enc_j(26'd2);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        base = ev_q.size();
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("abort.memadr_addr", 64'(addr), 64'h8);
        chk("abort.memadr_memwrite", 64'(memwrite), 64'h0);
        #1 reset = 1'b1;
        #1;
        chk("abort.async_addr", 64'(addr), 64'h0);
        chk("abort.async_memwrite", 64'(memwrite), 64'h0);
        repeat (3) begin
            @(negedge clk);
            chk("abort.held_memwrite", 64'(memwrite), 64'h0);
        end
        chk("abort.no_store", 64'(ev_q.size() - base), 64'h0);
        exp_q.delete();
        exp_q.push_back('{32'h200, 32'd5, 8});
        run_prog(14, base);
        chk("abort.restart_fetch", 64'(ff_addr), 64'h0);
        check_events("abort.rerun", base);

        // Single-operation vectors through two loads, the operation and a store.
        foreach (tbl[i]) begin
            clear_img();
            img[128] = tbl[i].a;
            img[129] = tbl[i].b;
            img[0] = enc_i(T_LW, 5'd1, 5'd0, 16'h0200);
            img[1] = enc_i(T_LW, 5'd2, 5'd0, 16'h0204);
            img[2] = enc_r(tbl[i].f, 5'd3, 5'd1, 5'd2);
            img[3] = enc_i(T_SW, 5'd3, 5'd0, 16'h0208);
            img[4] = enc_j(26'd4);
            exp_q.delete();
            exp_q.push_back('{32'h208, tbl[i].y, tbl[i].c});
            run_prog(tbl[i].c + 6, base);
            check_events($sformatf("vec%0d", i), base);
        end

        // Random programs against the instruction-level model.
        for (int p = 0; p < 6; p++) begin
            gen_random();
            model_run(tend);
            run_prog(tend + 8, base);
            check_events($sformatf("rand%0d", p), base);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
